// File: rtl/cfg_pkg.sv
// Shared definitions for the config latch write path: sizes, sequencer states
// and the reference index-to-enable decode.
package cfg_pkg;

  localparam int CFG_DATA_W    = 32;
  localparam int CFG_NUM_WORDS = 22;
  localparam int CFG_IDX_W     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SETUP  = 3'd2,
    PULSE  = 3'd3,
    HOLD   = 3'd4,
    FINISH = 3'd5
  } cfg_state_e;

  // Out-of-range indices decode to all-zero, never to a stray bit.
  function automatic logic [CFG_NUM_WORDS-1:0] onehot_en(input logic [CFG_IDX_W-1:0] idx);
    logic [CFG_NUM_WORDS-1:0] dec;
    dec = '0;
    for (int i = 0; i < CFG_NUM_WORDS; i++) begin
      dec[i] = (int'(idx) == i);
    end
    return dec;
  endfunction

endpackage

// File: rtl/cfg_onehot_dec.sv
// Registered word-index to one-hot decoder; the gate input forces all-zero so
// the output is either empty or exactly one bit below N.
module cfg_onehot_dec
  import cfg_pkg::*;
#(
  parameter int N     = CFG_NUM_WORDS,
  parameter int IDX_W = CFG_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     en
);

  logic [N-1:0] en_next;
  logic [N-1:0] en_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign en_next[gi] = gate && (idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg <= '0;
    end else begin
      en_reg <= en_next;
    end
  end

  assign en = en_reg;

endmodule

// File: rtl/configs_loader.sv
// Write-side sequencer for the config latch bank: accepts words over valid/ready
// and writes each to its latch with one cycle of data setup and hold.
module configs_loader
  import cfg_pkg::*;
#(
  parameter int DATA_W    = CFG_DATA_W,
  parameter int NUM_WORDS = CFG_NUM_WORDS,
  parameter int IDX_W     = CFG_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_cfg_valid,
  output logic                 io_cfg_ready,
  input  logic [DATA_W-1:0]    io_cfg_data,
  output logic [DATA_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  cfg_state_e        state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              ready_reg;
  logic [DATA_W-1:0] data_reg;
  logic              busy_reg;
  logic              done_reg;

  // Outputs are set on the edge entering each state so they are registered
  // and line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io_start) begin
            state_reg <= WAIT;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (io_cfg_valid && ready_reg) begin
            data_reg  <= io_cfg_data;
            ready_reg <= 1'b0;
            state_reg <= SETUP;
          end
        end
        SETUP: state_reg <= PULSE;
        PULSE: state_reg <= HOLD;
        HOLD: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= FINISH;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            ready_reg <= 1'b1;
            state_reg <= WAIT;
          end
        end
        FINISH: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gating on SETUP makes the registered enable high exactly during PULSE.
  cfg_onehot_dec #(
    .N     (NUM_WORDS),
    .IDX_W (IDX_W)
  ) u_dec (
    .clk   (clk),
    .reset (reset),
    .gate  (state_reg == SETUP),
    .idx   (idx_reg),
    .en    (io_configs_en)
  );

  assign io_cfg_ready = ready_reg;
  assign io_d_out     = data_reg;
  assign io_busy      = busy_reg;
  assign io_done      = done_reg;

endmodule
